// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit path.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 217;
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with wrap-bit pointers; head byte visible combinationally on dout.
// Pushes are dropped while full and pops are ignored while empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW:0]               wr_ptr_q;
    logic [AW:0]               rd_ptr_q;
    logic                      push_en;
    logic                      pop_en;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == FULL_CNT);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter fed by a byte FIFO; TXD falls one clock after a byte lands in an idle, empty FIFO.
// tx_ready drops only while the FIFO is full; frames are sent back to back with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [UART_DATA_BITS-1:0]     tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    tx_state_e                 state_q;
    logic [BW-1:0]             baud_q;
    logic [2:0]                bit_q;
    logic                      stop_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      txd_q;
    logic                      busy_q;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      bit_end;
    logic                      pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_valid),
        .din    (tx_data),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign TXD      = txd_q;
    assign busy     = busy_q;
    assign bit_end  = (baud_q == BAUD_LAST);

    // Popping at the end of the last stop bit chains frames without an idle cycle.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) ||
                  ((state_q == STOP) && bit_end && (stop_q == STOP_LAST)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            baud_q <= ((state_q == IDLE) || bit_end) ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_dout;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd_q   <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == BIT_LAST) begin
                            txd_q   <= 1'b1;
                            stop_q  <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_q == STOP_LAST) begin
                            if (pop) begin
                                shift_q <= fifo_dout;
                                txd_q   <= 1'b0;
                                state_q <= START;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx against a frame-level model and a time-based 8N1 sampler.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic       a_txd, b_txd;
    logic       a_busy, b_busy;
    logic [2:0] a_count, b_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] bp_seq [6];
    logic [7:0] lb_str [5];
    int         w3, wl, n_acc, guard, t;
    logic [7:0] rx_byte;
    logic       rx_start, rx_stop, seen;

    always #20 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(217), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .resetn(resetn), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .TXD(a_txd), .busy(a_busy), .fifo_count(a_count)
    );

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .resetn(resetn), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .TXD(b_txd), .busy(b_busy), .fifo_count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd_of(input bit sel);
        return sel ? b_txd : a_txd;
    endfunction

    // Line level of frame bit k: start, eight data bits LSB first, then stop bits.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Waits for a start bit, then checks every cycle of the frame; returns at the first cycle after it.
    task automatic check_frame(input bit sel, input int cpb, input int nstop,
                               input logic [7:0] exp_in, input bit from_q, input string tag);
        int         w;
        logic [7:0] exp;
        logic       eb, ob;
        w = 0;
        while (txd_of(sel) !== 1'b0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_start_found"}, 32'(w < 20000), 32'd1);
        if (w >= 20000) return;
        exp = exp_in;
        if (from_q) begin
            chk({tag, "_byte_expected"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() == 0) return;
            exp = exp_q.pop_front();
        end
        for (int k = 0; k < 9 + nstop; k++) begin
            eb = frame_bit(exp, k);
            ob = eb;
            for (int c = 0; c < cpb; c++) begin
                if (txd_of(sel) !== eb) ob = txd_of(sel);
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, k), 32'(ob), 32'(eb));
        end
    endtask

    task automatic push_a(input logic [7:0] d, output int waited);
        a_data  = d;
        a_valid = 1'b1;
        waited  = 0;
        while (!a_ready && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 8'($urandom);
    endtask

    initial begin
        bp_seq = '{8'h39, 8'h39, 8'h2F, 8'h30, 8'h33, 8'h41};
        lb_str = '{8'h34, 8'h35, 8'h2A, 8'h34, 8'h32};
        resetn  = 1'b0;
        a_valid = 1'b0;
        a_data  = 8'h00;
        b_valid = 1'b0;
        b_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(a_txd), 32'd1);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: latency, frame shape and busy release.
        a_data  = 8'h34;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 8'hFF;
        chk("t1_count_after_push", 32'(a_count), 32'd1);
        chk("t1_txd_still_idle", 32'(a_txd), 32'd1);
        @(negedge clk);
        chk("t1_txd_fall", 32'(a_txd), 32'd0);
        chk("t1_busy_set", 32'(a_busy), 32'd1);
        chk("t1_count_popped", 32'(a_count), 32'd0);
        check_frame(1'b0, 217, 1, 8'h34, 1'b0, "t1");
        chk("t1_busy_end", 32'(a_busy), 32'd0);
        chk("t1_txd_end", 32'(a_txd), 32'd1);

        // Back-to-back frames with no idle gap.
        repeat (5) @(negedge clk);
        push_a(8'h35, wl);
        push_a(8'h2A, wl);
        check_frame(1'b0, 217, 1, 8'h35, 1'b0, "t2a");
        chk("t2_no_gap", 32'(a_txd), 32'd0);
        check_frame(1'b0, 217, 1, 8'h2A, 1'b0, "t2b");
        chk("t2_busy_end", 32'(a_busy), 32'd0);

        // Backpressure: five in flight, sixth stalls until the first frame ends.
        repeat (5) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i == 5) begin
                        chk("t3_count_full", 32'(a_count), 32'd4);
                        chk("t3_ready_low", 32'(a_ready), 32'd0);
                    end
                    push_a(bp_seq[i], w3);
                    if (i == 5) chk("t3_stall_cycles", 32'(w3), 32'(217 * 10 - 3));
                end
            end
            begin
                for (int i = 0; i < 6; i++)
                    check_frame(1'b0, 217, 1, bp_seq[i], 1'b0, $sformatf("t3f%0d", i));
            end
        join
        chk("t3_busy_end", 32'(a_busy), 32'd0);

        // Reset during data bit 3 with two bytes queued.
        repeat (5) @(negedge clk);
        push_a(8'h42, wl);
        push_a(8'h11, wl);
        push_a(8'h22, wl);
        repeat (4 * 217 + 108 - 1) @(negedge clk);
        chk("t4_txd_bit3", 32'(a_txd), 32'd0);
        chk("t4_count_before", 32'(a_count), 32'd2);
        resetn = 1'b0;
        #1;
        chk("t4_txd_rst", 32'(a_txd), 32'd1);
        chk("t4_count_rst", 32'(a_count), 32'd0);
        chk("t4_busy_rst", 32'(a_busy), 32'd0);
        chk("t4_ready_rst", 32'(a_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if (a_txd !== 1'b1 || a_busy !== 1'b0) seen = 1'b1;
        end
        chk("t4_silent_after_reset", 32'(seen), 32'd0);

        // Loopback through a time-based 8N1 sampler at 8680 time units per bit.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    push_a(lb_str[i], wl);
                    chk($sformatf("t5_push%0d_taken", i), 32'(wl < 20000), 32'd1);
                end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    t = 0;
                    while (a_txd !== 1'b0 && t < 20000) begin
                        #10;
                        t++;
                    end
                    chk($sformatf("t5_start%0d_found", i), 32'(t < 20000), 32'd1);
                    if (t < 20000) begin
                        #4340;
                        rx_start = a_txd;
                        for (int b = 0; b < 8; b++) begin
                            #8680;
                            rx_byte[b] = a_txd;
                        end
                        #8680;
                        rx_stop = a_txd;
                        chk($sformatf("t5_start%0d_low", i), 32'(rx_start), 32'd0);
                        chk($sformatf("t5_byte%0d", i), 32'(rx_byte), 32'(lb_str[i]));
                        chk($sformatf("t5_stop%0d_high", i), 32'(rx_stop), 32'd1);
                    end
                end
            end
        join
        @(negedge clk);

        // Fast instance: 4 clocks per bit, two stop bits.
        b_data  = 8'hA5;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check_frame(1'b1, 4, 2, 8'hA5, 1'b0, "t6");
        chk("t6_busy_end", 32'(b_busy), 32'd0);

        // Random valid pattern and data; accepted bytes must come out in order.
        n_acc = 0;
        guard = 0;
        fork
            begin
                while (n_acc < 24 && guard < 50000) begin
                    b_valid = ($urandom_range(0, 3) != 0);
                    b_data  = 8'($urandom);
                    if (b_valid && b_ready) begin
                        exp_q.push_back(b_data);
                        n_acc++;
                    end
                    @(negedge clk);
                    guard++;
                end
                b_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 24; i++)
                    check_frame(1'b1, 4, 2, 8'h00, 1'b1, $sformatf("t7f%0d", i));
            end
        join
        repeat (4) @(negedge clk);
        chk("t7_all_sent", 32'(exp_q.size()), 32'd0);
        chk("t7_busy_end", 32'(b_busy), 32'd0);
        chk("t7_count_end", 32'(b_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter for the SOC serial port; the transmit-side counterpart of the SOC's UART receive path.
- Accepts bytes from the CPU-side IO write path through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte onto TXD as 8N1 (or 8N2) frames, LSB first.
- Default timing: 25 MHz clk, 115200 baud, 217 clocks per bit.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, number of buffered bytes; must be a power of 2, at least 2.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous reset, active-low.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte; a transfer occurs when tx_valid && tx_ready at a rising clk edge.
- TXD  out  1  serial line, idle high; registered output.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes waiting in the FIFO (excludes the byte in the shift register).

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - resetn low forces, asynchronously: TXD=1, busy=0, fifo_count=0, FIFO pointers=0, FSM=IDLE, baud counter=0, bit index=0.
  - tx_ready = !full, so tx_ready reads 1 during and after reset.
- FIFO:
  - Circular buffer; read and write pointers carry one extra wrap bit.
  - full when count==FIFO_DEPTH; empty when count==0.
  - Push and pop in the same cycle leave count unchanged.
  - A push is never taken while full; there is no overflow path.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TXD=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap between frames); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - Bit-end event when counter==CLKS_PER_BIT-1; the counter wraps to 0 on that event.
- Latency:
  - Byte accepted at edge N into an empty FIFO with the FSM in IDLE → popped at edge N+1, and TXD falls at edge N+1.
  - Frame length is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles, from the TXD falling edge to the end of the stop bit(s).
- busy: registered; asserted from the pop cycle until the FSM returns to IDLE with the FIFO empty.
- Boundary conditions:
  - Pop in IDLE/STOP and push in the same cycle → both happen; count is unchanged.
  - FIFO full plus one byte in the shift register → FIFO_DEPTH+1 bytes in flight; tx_ready=0 until the next pop.
  - Pointer wrap-around is transparent; byte order is strictly FIFO.
  - resetn asserted mid-frame → TXD returns high immediately, the frame is truncated, and the FIFO contents are discarded.
  - tx_data is ignored whenever tx_valid is low.

Decomposition:
- Package uart_pkg:
  - UART_DEFAULT_CLKS_PER_BIT=217.
  - UART_DATA_BITS=8.
  - FSM state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
- Sub-module uart_tx_fifo: synchronous FIFO with parameter DEPTH.
  - Ports: clk, resetn, push, din, pop, dout, full, empty, count.
  - dout shows the head byte combinationally.
- uart_tx holds the FSM, baud counter and shift register.

Test Plan:
- Single byte: push 0x34 once after reset → TXD low for 217 clks, then bits 0,0,1,0,1,1,0,0 (217 clks each), then high for 217. busy falls 2170 clks after the TXD falling edge.
- Back-to-back: push 0x35 then 0x2A on consecutive cycles → two frames with no idle gap; TXD high for exactly 217 clks between the 0x35 data bits and the 0x2A start bit; total 4340 clks.
- Backpressure: hold tx_valid with 0x39,0x39,0x2F,0x30,0x33,0x41 → first 5 accepted (1 in the shift register, 4 in the FIFO); tx_ready=0 on the 6th until the first frame ends; all 6 bytes appear in order on TXD.
- Reset mid-frame: assert resetn=0 during bit 3 of 0x42 with 2 bytes queued → TXD=1 the same cycle; fifo_count=0, busy=0, tx_ready=1. After release nothing further is transmitted.
- Parameters: CLKS_PER_BIT=4, STOP_BITS=2, push 0xA5 → each bit 4 clks, stop high 8 clks, frame = 44 clks.
- Loopback: connect TXD to a bench 8N1 sampler at 8680 ns/bit with tck=40 ns, push the "45*42" ASCII string → the decoded bytes match exactly, with no framing errors.
